// File: rtl/apb_pkg.sv
// Shared types for the multi-slave APB master: FSM states, response codes, width helper.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_e;

   localparam logic [1:0] APB_OK      = 2'b00;
   localparam logic [1:0] APB_SLVERR  = 2'b01;
   localparam logic [1:0] APB_TIMEOUT = 2'b10;
   localparam logic [1:0] APB_DECERR  = 2'b11;

   // Width of the slave index field; never narrower than one bit.
   function automatic int sel_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Slave decode: top address bits -> one-hot select plus decode-error flag.
// Latency: combinational.
// Backpressure: none.
module apb_addr_decode
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int NUM_SLAVES = 4
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic [NUM_SLAVES-1:0] sel,
   output logic                  dec_err
);

   localparam int SW = sel_width(NUM_SLAVES);
   localparam logic [SW:0] NS = (SW+1)'(NUM_SLAVES);

   logic [SW-1:0] idx;
   logic          unused_low_addr;

   assign idx             = addr[ADDR_WIDTH-1 -: SW];
   assign unused_low_addr = ^addr[ADDR_WIDTH-SW-1:0];
   assign dec_err         = ({1'b0, idx} >= NS);

   // One-hot select; an out-of-range index selects nothing.
   always_comb begin
      sel = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (!dec_err && (idx == SW'(i))) sel[i] = 1'b1;
      end
   end

endmodule

// File: rtl/apb_master_mc.sv
// Command-stream to APB3 master with NUM_SLAVES selects, wait-state timeout and error reporting.
// Latency: 3 cycles accept-to-response with zero wait states, +1 per wait state; decode error 1 cycle.
// Backpressure: cmd_ready low while a transfer is outstanding; response held until rsp_ready.
module apb_master_mc
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_SLAVES = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic                             Pclk,
   input  logic                             Presetn,
   input  logic                             cmd_valid,
   output logic                             cmd_ready,
   input  logic [ADDR_WIDTH-1:0]            cmd_addr,
   input  logic [DATA_WIDTH-1:0]            cmd_wdata,
   input  logic                             cmd_write,
   output logic                             rsp_valid,
   input  logic                             rsp_ready,
   output logic [DATA_WIDTH-1:0]            rsp_rdata,
   output logic [1:0]                       rsp_err,
   output logic [NUM_SLAVES-1:0]            Psel,
   output logic                             Penable,
   output logic                             Pwrite,
   output logic [ADDR_WIDTH-1:0]            Paddr,
   output logic [DATA_WIDTH-1:0]            Pwdata,
   input  logic [NUM_SLAVES-1:0]            Pready,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] Prdata,
   input  logic [NUM_SLAVES-1:0]            Pslverr
);

   localparam int          CW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW:0] TO_LIM = (CW+1)'(TIMEOUT);

   apb_state_e            state, state_nxt;
   logic [CW-1:0]         wait_cnt, wait_cnt_nxt;
   logic [CW:0]           cnt_inc;
   logic [NUM_SLAVES-1:0] dec_sel;
   logic                  dec_err;
   logic                  sel_ready, sel_err;
   logic [DATA_WIDTH-1:0] sel_rdata;

   logic                  cmd_ready_nxt, rsp_valid_nxt, penable_nxt, pwrite_nxt;
   logic [DATA_WIDTH-1:0] rsp_rdata_nxt, pwdata_nxt;
   logic [1:0]            rsp_err_nxt;
   logic [NUM_SLAVES-1:0] psel_nxt;
   logic [ADDR_WIDTH-1:0] paddr_nxt;

   apb_addr_decode #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_SLAVES (NUM_SLAVES)
   ) u_decode (
      .addr    (cmd_addr),
      .sel     (dec_sel),
      .dec_err (dec_err)
   );

   // Psel holds the latched one-hot target during SETUP/ACCESS, so it doubles as the return mux select.
   assign sel_ready = |(Pready & Psel);
   assign sel_err   = |(Pslverr & Psel);
   assign cnt_inc   = {1'b0, wait_cnt} + (CW+1)'(1);

   // AND-OR mux of the selected slave's read data.
   always_comb begin
      sel_rdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (Psel[i]) sel_rdata = sel_rdata | Prdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Next state and next value of every registered output.
   always_comb begin
      state_nxt     = state;
      wait_cnt_nxt  = wait_cnt;
      cmd_ready_nxt = cmd_ready;
      rsp_valid_nxt = rsp_valid;
      rsp_rdata_nxt = rsp_rdata;
      rsp_err_nxt   = rsp_err;
      psel_nxt      = Psel;
      penable_nxt   = Penable;
      pwrite_nxt    = Pwrite;
      paddr_nxt     = Paddr;
      pwdata_nxt    = Pwdata;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               cmd_ready_nxt = 1'b0;
               wait_cnt_nxt  = '0;
               if (dec_err) begin
                  state_nxt     = RESP;
                  rsp_valid_nxt = 1'b1;
                  rsp_err_nxt   = APB_DECERR;
                  rsp_rdata_nxt = '0;
               end else begin
                  state_nxt  = SETUP;
                  psel_nxt   = dec_sel;
                  paddr_nxt  = cmd_addr;
                  pwrite_nxt = cmd_write;
                  pwdata_nxt = cmd_wdata;
               end
            end
         end
         SETUP: begin
            state_nxt   = ACCESS;
            penable_nxt = 1'b1;
         end
         ACCESS: begin
            if (sel_ready) begin
               state_nxt     = RESP;
               psel_nxt      = '0;
               penable_nxt   = 1'b0;
               rsp_valid_nxt = 1'b1;
               rsp_err_nxt   = sel_err ? APB_SLVERR : APB_OK;
               rsp_rdata_nxt = (Pwrite || sel_err) ? '0 : sel_rdata;
            end else begin
               wait_cnt_nxt = cnt_inc[CW-1:0];
               if ((TIMEOUT != 0) && (cnt_inc == TO_LIM)) begin
                  state_nxt     = RESP;
                  psel_nxt      = '0;
                  penable_nxt   = 1'b0;
                  rsp_valid_nxt = 1'b1;
                  rsp_err_nxt   = APB_TIMEOUT;
                  rsp_rdata_nxt = '0;
               end
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_nxt     = IDLE;
               rsp_valid_nxt = 1'b0;
               cmd_ready_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt     = IDLE;
            cmd_ready_nxt = 1'b1;
         end
      endcase
   end

   // State and output registers; reset drops the bus immediately.
   always_ff @(posedge Pclk or negedge Presetn) begin
      if (!Presetn) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         cmd_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= APB_OK;
         Psel      <= '0;
         Penable   <= 1'b0;
         Pwrite    <= 1'b0;
         Paddr     <= '0;
         Pwdata    <= '0;
      end else begin
         state     <= state_nxt;
         wait_cnt  <= wait_cnt_nxt;
         cmd_ready <= cmd_ready_nxt;
         rsp_valid <= rsp_valid_nxt;
         rsp_rdata <= rsp_rdata_nxt;
         rsp_err   <= rsp_err_nxt;
         Psel      <= psel_nxt;
         Penable   <= penable_nxt;
         Pwrite    <= pwrite_nxt;
         Paddr     <= paddr_nxt;
         Pwdata    <= pwdata_nxt;
      end
   end

endmodule

// File: tb/tb_apb_master_mc.sv
// Bench for apb_master_mc: a 4-slave/TIMEOUT=4 instance and a 3-slave/no-timeout instance.
// Latency: each transfer's accept-to-response cycle count is checked against the derived value.
// Backpressure: response stalls with rsp_ready low while cmd_valid stays high.
module tb_apb_master_mc;

   typedef struct packed {
      logic [31:0] rdata;
      logic [1:0]  err;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         use_b = 1'b0;
   logic         cmd_valid = 1'b0;
   logic [31:0]  cmd_addr = '0;
   logic [31:0]  cmd_wdata = '0;
   logic         cmd_write = 1'b0;
   logic         rsp_ready = 1'b0;
   logic [3:0]   Pready = '0;
   logic [3:0]   Pslverr = '0;
   logic [127:0] Prdata = '0;

   logic         a_cmd_ready, a_rsp_valid, a_Penable, a_Pwrite;
   logic [31:0]  a_rsp_rdata, a_Paddr, a_Pwdata;
   logic [1:0]   a_rsp_err;
   logic [3:0]   a_Psel;
   logic         b_cmd_ready, b_rsp_valid, b_Penable, b_Pwrite;
   logic [31:0]  b_rsp_rdata, b_Paddr, b_Pwdata;
   logic [1:0]   b_rsp_err;
   logic [2:0]   b_Psel;

   logic         o_cmd_ready, o_rsp_valid, o_Penable, o_Pwrite;
   logic [31:0]  o_rsp_rdata, o_Paddr, o_Pwdata;
   logic [1:0]   o_rsp_err;
   logic [3:0]   o_Psel;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   apb_master_mc #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(4), .TIMEOUT(4)) dut_a (
      .Pclk(clk), .Presetn(rst_n),
      .cmd_valid(cmd_valid && !use_b), .cmd_ready(a_cmd_ready),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_write(cmd_write),
      .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready && !use_b),
      .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
      .Psel(a_Psel), .Penable(a_Penable), .Pwrite(a_Pwrite), .Paddr(a_Paddr), .Pwdata(a_Pwdata),
      .Pready(Pready), .Prdata(Prdata), .Pslverr(Pslverr)
   );

   apb_master_mc #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(3), .TIMEOUT(0)) dut_b (
      .Pclk(clk), .Presetn(rst_n),
      .cmd_valid(cmd_valid && use_b), .cmd_ready(b_cmd_ready),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_write(cmd_write),
      .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready && use_b),
      .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
      .Psel(b_Psel), .Penable(b_Penable), .Pwrite(b_Pwrite), .Paddr(b_Paddr), .Pwdata(b_Pwdata),
      .Pready(Pready[2:0]), .Prdata(Prdata[95:0]), .Pslverr(Pslverr[2:0])
   );

   // View of whichever instance the current transfer targets.
   always_comb begin
      o_cmd_ready = use_b ? b_cmd_ready : a_cmd_ready;
      o_rsp_valid = use_b ? b_rsp_valid : a_rsp_valid;
      o_rsp_rdata = use_b ? b_rsp_rdata : a_rsp_rdata;
      o_rsp_err   = use_b ? b_rsp_err   : a_rsp_err;
      o_Psel      = use_b ? {1'b0, b_Psel} : a_Psel;
      o_Penable   = use_b ? b_Penable : a_Penable;
      o_Pwrite    = use_b ? b_Pwrite  : a_Pwrite;
      o_Paddr     = use_b ? b_Paddr   : a_Paddr;
      o_Pwdata    = use_b ? b_Pwdata  : a_Pwdata;
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Drive one command, play the selected slave, and score the response.
   task automatic do_xfer(input logic b, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic wr, input int waits, input logic serr,
                          input logic [31:0] rd, input int hold, input logic keep);
      exp_t        e, got;
      logic [1:0]  idx;
      logic        dec, tmo;
      logic [3:0]  esel;
      int          tout, c, acc, exp_lat, exp_acc;
      idx  = addr[31:30];
      dec  = b && (idx == 2'd3);
      tout = b ? 0 : 4;
      tmo  = !dec && (tout != 0) && (waits >= tout);
      esel = dec ? 4'b0000 : (4'b0001 << idx);
      e.err   = dec ? 2'b11 : tmo ? 2'b10 : serr ? 2'b01 : 2'b00;
      e.rdata = (wr || e.err != 2'b00) ? 32'h0 : rd;
      exp_lat = dec ? 1 : tmo ? (2 + tout) : (3 + waits);
      exp_acc = dec ? 0 : tmo ? tout : (waits + 1);

      use_b = b;
      c = 0;
      while (!o_cmd_ready && c < 20) begin
         @(negedge clk);
         c++;
      end
      check_eq("cmd_ready_idle", 32'(o_cmd_ready), 32'd1);
      for (int i = 0; i < 4; i++) Prdata[i*32 +: 32] = esel[i] ? rd : (32'hBAD0_0000 | 32'(i));
      Pready    = ~esel;
      Pslverr   = ~esel;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      cmd_write = wr;
      cmd_valid = 1'b1;
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      if (!keep) cmd_valid = 1'b0;
      c   = 1;
      acc = 0;
      while (!o_rsp_valid && c < 50) begin
         if (c == 1) begin
            check_eq("setup_psel", 32'(o_Psel), 32'(esel));
            check_eq("setup_penable", 32'(o_Penable), 32'd0);
            check_eq("setup_paddr", o_Paddr, addr);
            check_eq("setup_pwrite", 32'(o_Pwrite), 32'(wr));
            if (wr) check_eq("setup_pwdata", o_Pwdata, wdata);
         end
         if (o_Penable) begin
            acc++;
            check_eq("access_psel", 32'(o_Psel), 32'(esel));
            // Selected slave: busy (and flagging a spurious error) until its wait count is served.
            Pready  = (acc > waits) ? 4'hF : ~esel;
            Pslverr = (acc > waits && !serr) ? ~esel : 4'hF;
         end
         @(posedge clk);
         @(negedge clk);
         c++;
      end
      Pready  = 4'h0;
      Pslverr = 4'h0;
      check_eq("latency", 32'(c), 32'(exp_lat));
      check_eq("access_cycles", 32'(acc), 32'(exp_acc));
      check_eq("resp_psel", 32'(o_Psel), 32'd0);
      check_eq("resp_penable", 32'(o_Penable), 32'd0);
      for (int h = 0; h < hold; h++) begin
         check_eq("stall_valid", 32'(o_rsp_valid), 32'd1);
         check_eq("stall_err", 32'(o_rsp_err), 32'(e.err));
         check_eq("stall_rdata", o_rsp_rdata, e.rdata);
         check_eq("stall_cmd_ready", 32'(o_cmd_ready), 32'd0);
         @(posedge clk);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      cmd_valid = 1'b0;
      if (exp_q.size() == 0) begin
         check_eq("queue_empty", 32'd1, 32'd0);
      end else begin
         got = exp_q.pop_front();
         check_eq("rsp_valid", 32'(o_rsp_valid), 32'd1);
         check_eq("rsp_err", 32'(o_rsp_err), 32'(got.err));
         check_eq("rsp_rdata", o_rsp_rdata, got.rdata);
      end
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      check_eq("rsp_drop", 32'(o_rsp_valid), 32'd0);
      check_eq("cmd_ready_back", 32'(o_cmd_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      check_eq("rst_cmd_ready", 32'(a_cmd_ready), 32'd1);
      check_eq("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
      check_eq("rst_psel", 32'(a_Psel), 32'd0);
      check_eq("rst_penable", 32'(a_Penable), 32'd0);
      check_eq("rst_paddr", a_Paddr, 32'd0);
      check_eq("rst_pwdata", a_Pwdata, 32'd0);
      check_eq("rst_rdata_err", {a_rsp_rdata[29:0], a_rsp_err}, 32'd0);
      check_eq("rst_b_cmd_ready", 32'(b_cmd_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      //       b     addr          wdata         wr    waits serr  rd            hold keep
      do_xfer(1'b0, 32'h4000_0010, 32'hDEAD_BEEF, 1'b1, 0,    1'b0, 32'h1111_1111, 0,   1'b0);
      do_xfer(1'b0, 32'hC000_0004, 32'h0,         1'b0, 3,    1'b0, 32'h1234_5678, 0,   1'b0);
      do_xfer(1'b0, 32'h0000_0008, 32'h0,         1'b0, 0,    1'b1, 32'hCAFE_0001, 0,   1'b0);
      do_xfer(1'b0, 32'h8000_0000, 32'h0,         1'b0, 100,  1'b0, 32'h5555_AAAA, 0,   1'b0);
      do_xfer(1'b0, 32'h8000_0040, 32'h0,         1'b0, 3,    1'b0, 32'h0BAD_F00D, 0,   1'b0);
      do_xfer(1'b1, 32'hC000_0000, 32'h0,         1'b0, 0,    1'b0, 32'h7777_7777, 0,   1'b0);
      do_xfer(1'b1, 32'h8000_0020, 32'h0,         1'b0, 1,    1'b0, 32'hA5A5_0002, 0,   1'b0);
      do_xfer(1'b1, 32'h4000_0000, 32'h0,         1'b0, 6,    1'b0, 32'h6666_0001, 0,   1'b0);
      do_xfer(1'b0, 32'h4000_0100, 32'h0,         1'b0, 1,    1'b0, 32'h0F0F_F0F0, 5,   1'b1);
      do_xfer(1'b0, 32'h0000_0200, 32'h1357_9BDF, 1'b1, 2,    1'b1, 32'h2222_2222, 2,   1'b1);

      // Reset in the middle of an ACCESS phase.
      use_b     = 1'b0;
      Pready    = 4'h0;
      cmd_addr  = 32'h4000_0000;
      cmd_write = 1'b0;
      cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_eq("pre_rst_penable", 32'(a_Penable), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("arst_psel", 32'(a_Psel), 32'd0);
      check_eq("arst_penable", 32'(a_Penable), 32'd0);
      check_eq("arst_cmd_ready", 32'(a_cmd_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_eq("arst_no_rsp", 32'(a_rsp_valid), 32'd0);
      end
      do_xfer(1'b0, 32'hC000_0000, 32'h0, 1'b0, 0, 1'b0, 32'h9999_0003, 0, 1'b0);
      check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
